// File: rtl/pbs_pkg.sv
// Shared types and constants for the PBS battle datapath.
// The optional critical-hit logic is enabled by defining PBS_CRIT_EN.
package pbs_pkg;

  typedef logic [1:0] move_idx_t;

  localparam logic PLAYER = 1'b0;
  localparam logic AI     = 1'b1;

  localparam int unsigned POWER_0 = 10;
  localparam int unsigned POWER_1 = 20;
  localparam int unsigned POWER_2 = 30;
  localparam int unsigned POWER_3 = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR with taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/pbs_move_rom.sv
// Move index to attack power lookup; kept separate so the move set can change alone.
module pbs_move_rom
  import pbs_pkg::*;
#(
  parameter int HP_W = 8
) (
  input  move_idx_t        i_idx,
  output logic [HP_W-1:0]  o_power
);

  always_comb begin
    o_power = HP_W'(POWER_0);
    case (i_idx)
      2'd0: o_power = HP_W'(POWER_0);
      2'd1: o_power = HP_W'(POWER_1);
      2'd2: o_power = HP_W'(POWER_2);
      2'd3: o_power = HP_W'(POWER_3);
      default: o_power = HP_W'(POWER_0);
    endcase
  end

endmodule

// File: rtl/pbs_battle_datapath.sv
// Battle datapath: move registers, both HP values and a one-point-per-tick HP drain.
// Define PBS_CRIT_EN to add LFSR-driven critical hits that double the damage.
module pbs_battle_datapath
  import pbs_pkg::*;
#(
  parameter int HP_W      = 8,
  parameter int MAX_HP    = 100,
  parameter int DRAIN_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_move,
  input  logic              active_trainer,
  input  logic [1:0]        move_sel,
  input  logic              apply_damage,
  input  logic              target,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   ai_hp,
  output logic              busy,
  output logic              dmg_done,
  output logic              hp_is_zero,
  output logic              crit_flag,
  output drain_state_e      dbg_state
);

  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  drain_state_e      r_state, w_next_state;
  move_idx_t         r_p_move, r_ai_move;
  logic [HP_W-1:0]   r_p_hp, r_ai_hp, r_rem;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_tgt, r_apply_q;

  logic [HP_W-1:0]   w_power, w_rem_init, w_tgt_hp;
  logic              w_start, w_tick, w_stop_now, w_last;

  // The attacker is the trainer that is not the target.
  pbs_move_rom #(.HP_W(HP_W)) u_rom (
    .i_idx   (target ? r_p_move : r_ai_move),
    .o_power (w_power)
  );

  assign w_start    = apply_damage & ~r_apply_q & (r_state == IDLE);
  assign w_tgt_hp   = r_tgt ? r_ai_hp : r_p_hp;
  assign w_tick     = (r_div_cnt == DIV_W'(DRAIN_DIV - 1));
  assign w_stop_now = (r_rem == '0) || (w_tgt_hp == '0);
  assign w_last     = w_tick && ((r_rem == HP_W'(1)) || (w_tgt_hp == HP_W'(1)));

`ifdef PBS_CRIT_EN
  logic [7:0]  r_lfsr;
  logic        r_crit, w_crit;
  logic [HP_W:0] w_dbl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
      r_crit <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_start) r_crit <= w_crit;
    end
  end

  assign w_crit     = (r_lfsr[3:0] == 4'h0);
  assign w_dbl      = {w_power, 1'b0};
  assign w_rem_init = !w_crit ? w_power : (w_dbl[HP_W] ? '1 : w_dbl[HP_W-1:0]);
  assign crit_flag  = r_crit;
`else
  assign w_rem_init = w_power;
  assign crit_flag  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = DRAIN;
      DRAIN:   if (w_stop_now || w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == DRAIN);
    dmg_done = (r_state == DONE);
  end

  // Victim and amount are latched at start, so later input changes cannot alter a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_hp    <= HP_W'(MAX_HP);
      r_ai_hp   <= HP_W'(MAX_HP);
      r_p_move  <= '0;
      r_ai_move <= '0;
      r_rem     <= '0;
      r_tgt     <= 1'b0;
      r_apply_q <= 1'b0;
      r_div_cnt <= '0;
    end else begin
      r_apply_q <= apply_damage;
      if (ld_move) begin
        if (active_trainer == AI) r_ai_move <= move_sel;
        else                      r_p_move  <= move_sel;
      end
      if (w_start) begin
        r_tgt     <= target;
        r_rem     <= w_rem_init;
        r_div_cnt <= '0;
      end else if ((r_state == DRAIN) && !w_stop_now) begin
        if (w_tick) begin
          r_div_cnt <= '0;
          r_rem     <= r_rem - HP_W'(1);
          if (r_tgt) r_ai_hp <= r_ai_hp - HP_W'(1);
          else       r_p_hp  <= r_p_hp - HP_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign p_hp       = r_p_hp;
  assign ai_hp      = r_ai_hp;
  assign hp_is_zero = ((target ? r_ai_hp : r_p_hp) == '0) && !busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pbs_battle_datapath.sv
// Self-checking bench for pbs_battle_datapath: fixed vector table, corner sequences,
// and randomized attacks checked against a battle-level reference model.
module tb_pbs_battle_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_move = 1'b0;
  logic       active_trainer = 1'b0;
  logic [1:0] move_sel = 2'd0;
  logic       apply_damage = 1'b0;
  logic       target = 1'b1;
  logic [7:0] p_hp, ai_hp;
  logic       busy, dmg_done, hp_is_zero, crit_flag;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  int m_p_hp, m_ai_hp, m_p_move, m_ai_move, m_crit;

  pbs_battle_datapath #(.HP_W(8), .MAX_HP(100), .DRAIN_DIV(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .ld_move        (ld_move),
    .active_trainer (active_trainer),
    .move_sel       (move_sel),
    .apply_damage   (apply_damage),
    .target         (target),
    .p_hp           (p_hp),
    .ai_hp          (ai_hp),
    .busy           (busy),
    .dmg_done       (dmg_done),
    .hp_is_zero     (hp_is_zero),
    .crit_flag      (crit_flag),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef PBS_CRIT_EN
  logic [7:0] m_lfsr = 8'hA5;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  function automatic int power(input int m);
    return 10 * (m + 1);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apply_damage = 1'b0;
    ld_move = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_p_hp = 100; m_ai_hp = 100;
    m_p_move = 0; m_ai_move = 0;
    m_crit = 0;
  endtask

  task automatic load_move(input int tr, input int mv);
    @(negedge clk);
    ld_move = 1'b1;
    active_trainer = tr[0];
    move_sel = mv[1:0];
    @(negedge clk);
    ld_move = 1'b0;
    if (tr != 0) m_ai_move = mv;
    else         m_p_move  = mv;
  endtask

  // One attack: apply_damage held for the whole drain plus `extra` idle cycles.
  task automatic attack(input int tgt, input int extra, input bit disturb);
    logic [7:0] exp_q[$];
    int pw, h, d, dn, hold, other, pulses, done_at, bad, exp_crit, act_hp, act_other;
    @(negedge clk);
    pw = power(tgt != 0 ? m_p_move : m_ai_move);
    exp_crit = 0;
`ifdef PBS_CRIT_EN
    if (m_lfsr[3:0] == 4'h0) begin
      pw = imin(2 * pw, 255);
      exp_crit = 1;
    end
`endif
    h     = (tgt != 0) ? m_ai_hp : m_p_hp;
    other = (tgt != 0) ? m_p_hp : m_ai_hp;
    d     = imin(pw, h);
    dn    = (d > 0) ? d : 1;
    hold  = dn + 2 + extra;
    for (int j = 1; j <= hold; j++) exp_q.push_back(8'(h - imin(j - 1, d)));
    target = tgt[0];
    apply_damage = 1'b1;
    pulses = 0; done_at = 0; bad = 0;
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      act_hp    = (tgt != 0) ? int'(ai_hp) : int'(p_hp);
      act_other = (tgt != 0) ? int'(p_hp) : int'(ai_hp);
      if (act_hp != int'(exp_q.pop_front())) bad++;
      if (act_other != other) bad++;
      if (busy != (j <= dn)) bad++;
      if (dmg_done) begin
        pulses++;
        done_at = j;
      end
      if (disturb && j == 2) begin
        target = ~tgt[0];
        ld_move = 1'b1;
        active_trainer = (tgt != 0) ? 1'b0 : 1'b1;
        move_sel = 2'd3;
      end
      if (disturb && j == 3) begin
        target = tgt[0];
        ld_move = 1'b0;
      end
    end
    if (disturb) begin
      if (tgt != 0) m_p_move = 3;
      else          m_ai_move = 3;
    end
    if (tgt != 0) m_ai_hp = h - d;
    else          m_p_hp  = h - d;
    m_crit = exp_crit;
    check("drain_trajectory_errs", bad, 0);
    check("dmg_done_pulses", pulses, 1);
    check("dmg_done_cycle", done_at, dn + 1);
    check("p_hp_after", int'(p_hp), m_p_hp);
    check("ai_hp_after", int'(ai_hp), m_ai_hp);
    check("hp_is_zero_after", int'(hp_is_zero), ((tgt != 0 ? m_ai_hp : m_p_hp) == 0) ? 1 : 0);
    check("crit_flag_after", int'(crit_flag), m_crit);
    apply_damage = 1'b0;
  endtask

  typedef struct {
    bit rst;
    int tr;
    int mv;
    int tgt;
    int ep;
    int eai;
    int ez;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
    vecs[0] = '{1'b1, 0, 2, 1, 100, 70, 0};
    vecs[1] = '{1'b1, 0, 3, 1, 100, 60, 0};
    vecs[2] = '{1'b0, 0, 3, 1, 100, 20, 0};
    vecs[3] = '{1'b0, 0, 0, 1, 100, 10, 0};
    vecs[4] = '{1'b0, 0, 3, 1, 100,  0, 1};
    vecs[5] = '{1'b0, 1, 1, 0,  80,  0, 0};
    vecs[6] = '{1'b0, 1, 3, 0,  40,  0, 0};
    vecs[7] = '{1'b0, 0, 0, 1,  40,  0, 1};

    do_reset();
    check("reset_p_hp", int'(p_hp), 100);
    check("reset_ai_hp", int'(ai_hp), 100);
    check("reset_busy", int'(busy), 0);
    check("reset_dmg_done", int'(dmg_done), 0);
    check("reset_crit_flag", int'(crit_flag), 0);
    check("reset_hp_is_zero", int'(hp_is_zero), 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      load_move(vecs[i].tr, vecs[i].mv);
      attack(vecs[i].tgt, 3, 1'b0);
`ifndef PBS_CRIT_EN
      check($sformatf("vec%0d_p_hp", i), int'(p_hp), vecs[i].ep);
      check($sformatf("vec%0d_ai_hp", i), int'(ai_hp), vecs[i].eai);
      check($sformatf("vec%0d_hp_is_zero", i), int'(hp_is_zero), vecs[i].ez);
`endif
    end

    // Long apply_damage hold with mid-drain target and move changes.
    do_reset();
    load_move(0, 1);
    attack(1, 180, 1'b1);
    load_move(1, 0);
    attack(0, 2, 1'b1);

    // Reset in the middle of a 30-point drain.
    do_reset();
    load_move(0, 2);
    @(negedge clk);
    target = 1'b1;
    apply_damage = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_drain_ai_hp", int'(ai_hp), 91);
    check("mid_drain_busy", int'(busy), 1);
    reset = 1'b1;
    apply_damage = 1'b0;
    @(negedge clk);
    check("abort_p_hp", int'(p_hp), 100);
    check("abort_ai_hp", int'(ai_hp), 100);
    check("abort_busy", int'(busy), 0);
    check("abort_dmg_done", int'(dmg_done), 0);
    reset = 1'b0;
    m_p_hp = 100; m_ai_hp = 100; m_p_move = 0; m_ai_move = 0; m_crit = 0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (dmg_done) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Randomized battle against the reference model.
    for (int n = 0; n < 40; n++) begin
      if (m_p_hp == 0 || m_ai_hp == 0) do_reset();
      if ($urandom_range(0, 1) == 1) load_move(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      attack(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
    end

`ifdef PBS_CRIT_EN
    do_reset();
    load_move(0, 0);
    for (int n = 0; n < 64; n++) begin
      int before;
      if (m_ai_hp < 25) begin
        do_reset();
        load_move(0, 0);
      end
      before = m_ai_hp;
      attack(1, int'($urandom_range(0, 3)), 1'b0);
      check("crit_damage_amount", before - int'(ai_hp), (m_crit != 0) ? 20 : 10);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
